axi_burst_gen: RTL and testbench

//  Initiator-side AXI address-channel generator: accepts a linear transfer command (start addr, byte count)
//  and issues it as a sequence of INCR bursts on an AR/AW-style channel (valid/ready).

---
 rtl/axi_burst_gen.sv | 143 ++++++++++++++
 tb/tb_axi_burst_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_gen.sv
// rtl/axi_burst_gen.sv - AXI INCR address-channel burst generator
// Splits a linear byte command into bursts limited by MAX_LEN beats and 4 KB boundaries.
module axi_burst_gen #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LEN    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [CNT_WIDTH-1:0]  cmd_bytes,
  output logic [ADDR_WIDTH-1:0] axaddr,
  output logic [7:0]            axlen,
  output logic [2:0]            axsize,
  output logic [1:0]            axburst,
  output logic                  axvalid,
  input  logic                  axready,
  output logic                  busy,
  output logic                  done
);

  localparam int BPB      = DATA_WIDTH / 8;
  localparam int SZ       = $clog2(BPB);
  localparam int BND_BITS = (ADDR_WIDTH < 12) ? ADDR_WIDTH : 12;
  localparam int TW       = BND_BITS + 1;
  localparam int CW_A     = (CNT_WIDTH > TW) ? CNT_WIDTH : TW;
  localparam int CW2      = (CW_A > 9) ? CW_A : 9;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [CNT_WIDTH-1:0]  r_rem_beats;
  logic [8:0]            r_beats;
  logic [ADDR_WIDTH-1:0] r_axaddr;
  logic [7:0]            r_axlen;
  logic                  r_axvalid;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_cmd_ready;

  logic                  w_frac;
  logic [CNT_WIDTH-1:0]  w_cmd_beats;
  logic [TW-1:0]         w_to_bnd;
  logic [CW2-1:0]        w_rem_x;
  logic [CW2-1:0]        w_bnd_x;
  logic [CW2-1:0]        w_cap_x;
  logic [8:0]            w_beats;
  logic [ADDR_WIDTH-1:0] w_step;
  logic [CNT_WIDTH-1:0]  w_rem_next;

  assign w_frac      = (cmd_bytes & CNT_WIDTH'(BPB - 1)) != '0;
  assign w_cmd_beats = (cmd_bytes >> SZ) + CNT_WIDTH'(w_frac);

  // Beats left before the next boundary; never zero because cur_addr is beat aligned.
  assign w_to_bnd = ((TW'(1) << BND_BITS) - TW'(r_cur_addr[BND_BITS-1:0])) >> SZ;
  assign w_rem_x  = CW2'(r_rem_beats);
  assign w_bnd_x  = CW2'(w_to_bnd);

  always_comb begin
    w_cap_x = CW2'(MAX_LEN);
    w_beats = 9'(MAX_LEN);
    if (w_bnd_x < w_cap_x) begin
      w_cap_x = w_bnd_x;
      w_beats = w_bnd_x[8:0];
    end
    if (w_rem_x < w_cap_x) begin
      w_beats = w_rem_x[8:0];
    end
  end

  assign w_step     = ADDR_WIDTH'(r_beats) << SZ;
  assign w_rem_next = r_rem_beats - CNT_WIDTH'(r_beats);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_rem_beats <= '0;
      r_beats     <= '0;
      r_axaddr    <= '0;
      r_axlen     <= '0;
      r_axvalid   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_ready <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_cur_addr  <= cmd_addr & ~ADDR_WIDTH'(BPB - 1);
            r_rem_beats <= w_cmd_beats;
            if (w_cmd_beats == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state     <= S_CALC;
              r_busy      <= 1'b1;
              r_cmd_ready <= 1'b0;
            end
          end
        end
        S_CALC: begin
          r_beats   <= w_beats;
          r_axaddr  <= r_cur_addr;
          r_axlen   <= 8'(w_beats - 9'd1);
          r_axvalid <= 1'b1;
          r_state   <= S_ISSUE;
        end
        S_ISSUE: begin
          if (axready) begin
            r_cur_addr  <= r_cur_addr + w_step;
            r_rem_beats <= w_rem_next;
            r_axvalid   <= 1'b0;
            if (w_rem_next == '0) begin
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_cmd_ready <= 1'b1;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign axaddr    = r_axaddr;
  assign axlen     = r_axlen;
  assign axsize    = 3'(SZ);
  assign axburst   = 2'b01;
  assign axvalid   = r_axvalid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_axi_burst_gen.sv
// tb/tb_axi_burst_gen.sv - scoreboard bench for axi_burst_gen
// Driver pushes model bursts per command; a negedge monitor pops and compares.
module tb_axi_burst_gen;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_addr;
  logic [15:0] cmd_bytes;
  logic [11:0] axaddr;
  logic [7:0]  axlen;
  logic [2:0]  axsize;
  logic [1:0]  axburst;
  logic        axvalid;
  logic        axready = 1'b1;
  logic        busy;
  logic        done;

  axi_burst_gen #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MAX_LEN(16), .CNT_WIDTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_bytes(cmd_bytes),
    .axaddr(axaddr), .axlen(axlen), .axsize(axsize), .axburst(axburst),
    .axvalid(axvalid), .axready(axready), .busy(busy), .done(done)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int addr;
    int len;
    bit last;
  } burst_t;

  burst_t exp_q[$];
  bit     done_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     rdy_mode = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic walk over the command, one entry per burst.
  task automatic model_push(input int addr, input int bytes);
    int a, n, to_b, b;
    a = addr & 'hFFC;
    n = (bytes + 3) / 4;
    if (n == 0) begin
      done_q.push_back(1'b1);
    end else begin
      while (n > 0) begin
        to_b = (4096 - (a % 4096)) / 4;
        b = n;
        if (b > 16) b = 16;
        if (b > to_b) b = to_b;
        exp_q.push_back('{addr: a, len: b - 1, last: (n - b) == 0});
        a = (a + b * 4) % 4096;
        n = n - b;
      end
      done_q.push_back(1'b0);
    end
  endtask

  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      0:       axready = 1'b1;
      1:       axready = ($urandom_range(0, 3) != 0);
      default: axready = 1'b0;
    endcase
  end

  bit     held = 0;
  int     h_addr, h_len;
  int     gap = 0;
  bit     done_next = 0;
  burst_t e;
  bit     tok;

  always @(negedge aclk) begin
    if (!aresetn) begin
      held = 0; gap = 0; done_next = 0;
    end else begin
      if (held) begin
        chk("hold_valid", axvalid, 1);
        chk("hold_addr", axaddr, h_addr);
        chk("hold_len", axlen, h_len);
      end
      if (gap == 1) begin
        chk("gap_idle", axvalid, 0);
        gap = 2;
      end else if (gap == 2) begin
        chk("gap_revalid", axvalid, 1);
        gap = 0;
      end
      if (done_next) chk("done_pulse", done, 1);
      if (done) begin
        chk("done_token_present", done_q.size() != 0, 1);
        if (done_q.size() != 0) begin
          tok = done_q.pop_front();
          if (!tok) chk("done_timing", done_next, 1);
        end
      end
      done_next = 0;
      if (axvalid) chk("busy_with_valid", busy, 1);
      if (axvalid && axready) begin
        chk("axsize", axsize, 2);
        chk("axburst", axburst, 1);
        chk("burst_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("axaddr", axaddr, e.addr);
          chk("axlen", axlen, e.len);
          if (e.last) done_next = 1;
          else gap = 1;
        end
      end
      held   = axvalid && !axready;
      h_addr = axaddr;
      h_len  = axlen;
    end
  end

  task automatic send(input int addr, input int bytes);
    int k;
    k = 0;
    while (!cmd_ready && k < 2000) begin
      @(negedge aclk);
      k++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = addr[11:0];
    cmd_bytes = bytes[15:0];
    @(posedge aclk);
    model_push(addr, bytes);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = 12'($urandom);
    cmd_bytes = 16'($urandom);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    do begin
      @(negedge aclk);
      k++;
    end while (!done && k < 5000);
    chk("done_wait", done, 1);
  endtask

  task automatic run_cmd(input int addr, input int bytes);
    send(addr, bytes);
    wait_done();
  endtask

  task automatic wait_axvalid();
    int k;
    k = 0;
    while (!axvalid && k < 100) begin
      @(negedge aclk);
      k++;
    end
    chk("axvalid_wait", axvalid, 1);
  endtask

  initial begin
    aresetn = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_bytes = '0;
    repeat (3) @(negedge aclk);
    chk("rst_axvalid", axvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_axaddr", axaddr, 0);
    chk("rst_axlen", axlen, 0);
    chk("rst_axsize", axsize, 2);
    chk("rst_axburst", axburst, 1);
    #2 aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);

    run_cmd('h000, 64);
    run_cmd('h000, 100);
    run_cmd('hFF0, 32);
    run_cmd('h003, 10);
    run_cmd('h000, 0);
    chk("zero_cmd_ready", cmd_ready, 1);
    chk("zero_no_valid", axvalid, 0);

    rdy_mode = 2;
    send('h000, 64);
    wait_axvalid();
    repeat (5) @(negedge aclk);
    rdy_mode = 0;
    wait_done();

    rdy_mode = 2;
    send('h000, 100);
    wait_axvalid();
    @(negedge aclk);
    #2 aresetn = 1'b0;
    exp_q.delete();
    done_q.delete();
    #1;
    chk("rst_mid_axvalid", axvalid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    repeat (2) @(negedge aclk);
    rdy_mode = 0;
    #2 aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    chk("rst_mid_no_done", done, 0);
    run_cmd('h000, 64);

    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      int sel, bytes;
      sel = $urandom_range(0, 9);
      if (sel == 0) bytes = 0;
      else if (sel < 6) bytes = $urandom_range(1, 128);
      else bytes = $urandom_range(129, 3000);
      run_cmd($urandom_range(0, 4095), bytes);
    end

    rdy_mode = 0;
    repeat (5) @(negedge aclk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    chk("final_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
